// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg
//   Shared definitions for the byte-lane data memory load/store unit:
//   RV32I funct3 encodings for loads/stores, the lane count and a helper that
//   classifies a request into an access size (or marks it as unsupported).
package dmem_lsu_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_BAD = 2'd3
  } size_e;

  // Stores only have the signed encodings; the unsigned byte/half forms
  // exist for loads alone.
  function automatic size_e decode_size(input logic we, input logic [2:0] funct3);
    size_e sz;
    sz = SIZE_BAD;
    case (funct3)
      F3_B:    sz = SIZE_B;
      F3_H:    sz = SIZE_H;
      F3_W:    sz = SIZE_W;
      F3_BU:   sz = we ? SIZE_BAD : SIZE_B;
      F3_HU:   sz = we ? SIZE_BAD : SIZE_H;
      default: sz = SIZE_BAD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align
//   Purely combinational load extractor. Picks the addressed byte or half
//   out of the four lane read bytes and sign- or zero-extends it to 32 bits.
//   Ports:
//     lane_dout  in  32  byte i from lane i
//     funct3     in  3   load funct3 of the pending request
//     off        in  2   byte offset within the word
//     rdata      out 32  extended load data (0 for non-load encodings)
module dmem_load_align
  import dmem_lsu_pkg::*;
(
  input  logic [8*LANES-1:0] lane_dout,
  input  logic [2:0]         funct3,
  input  logic [1:0]         off,
  output logic [31:0]        rdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = lane_dout[7:0];
    case (off)
      2'd0:    sel_byte = lane_dout[7:0];
      2'd1:    sel_byte = lane_dout[15:8];
      2'd2:    sel_byte = lane_dout[23:16];
      default: sel_byte = lane_dout[31:24];
    endcase
    // Halves are always 2-byte aligned by the time they get here.
    sel_half = off[1] ? lane_dout[31:16] : lane_dout[15:0];

    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata = {24'd0, sel_byte};
      F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata = {16'd0, sel_half};
      F3_W:    rdata = lane_dout;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu
//   Load/store front end for four 8-bit lane BRAMs (1-cycle registered read,
//   read data held while read enable is low). One request per cycle; the
//   response appears the following cycle from a single pending register.
//   Misaligned or unsupported accesses are reported via RSP_ERR and never
//   touch memory.
//   Ports:
//     CLK, RST                      clock, synchronous active-high reset
//     REQ_VALID/REQ_READY           request handshake
//     REQ_WE, REQ_FUNCT3            store/load select, RV32I funct3
//     REQ_ADDR, REQ_WDATA           byte address, LSB-justified store data
//     RSP_VALID/RSP_READY           response handshake
//     RSP_RDATA, RSP_ERR            extended load data, error flag
//     LANE_W_ADDR, LANE_R_ADDR      shared word addresses for all lanes
//     LANE_WE, LANE_RE              per-lane write/read enables
//     LANE_DIN, LANE_DOUT           lane write/read data, byte i <-> lane i
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [2:0]            REQ_FUNCT3,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [ADDR_WIDTH-3:0] LANE_W_ADDR,
  output logic [ADDR_WIDTH-3:0] LANE_R_ADDR,
  output logic [LANES-1:0]      LANE_WE,
  output logic [LANES-1:0]      LANE_RE,
  output logic [8*LANES-1:0]    LANE_DIN,
  input  logic [8*LANES-1:0]    LANE_DOUT
);

  logic [1:0]  req_off;
  size_e       req_size;
  logic        req_err;
  logic        accept;

  logic        p_valid;
  logic        p_we;
  logic        p_err;
  logic [2:0]  p_funct3;
  logic [1:0]  p_off;

  logic [31:0] aligned_rdata;

  assign req_off  = REQ_ADDR[1:0];
  assign req_size = decode_size(REQ_WE, REQ_FUNCT3);

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_B:  req_err = 1'b0;
      SIZE_H:  req_err = req_off[0];
      SIZE_W:  req_err = (req_off != 2'd0);
      default: req_err = 1'b1;
    endcase
  end

  // A held response blocks new requests; with the lanes idle their registered
  // read data stays put, which keeps RSP_RDATA stable under backpressure.
  assign REQ_READY = !RST && !(p_valid && !RSP_READY);
  assign accept    = REQ_VALID && REQ_READY;

  assign LANE_W_ADDR = REQ_ADDR[ADDR_WIDTH-1:2];
  assign LANE_R_ADDR = REQ_ADDR[ADDR_WIDTH-1:2];

  always_comb begin
    LANE_WE = '0;
    LANE_RE = '0;
    case (req_size)
      SIZE_B:  LANE_DIN = {4{REQ_WDATA[7:0]}};
      SIZE_H:  LANE_DIN = {2{REQ_WDATA[15:0]}};
      default: LANE_DIN = REQ_WDATA;
    endcase
    if (accept && !req_err) begin
      if (REQ_WE) begin
        case (req_size)
          SIZE_B:  LANE_WE = 4'b0001 << req_off;
          SIZE_H:  LANE_WE = 4'b0011 << req_off;
          SIZE_W:  LANE_WE = 4'b1111;
          default: LANE_WE = '0;
        endcase
      end else begin
        // Loads read the whole word; byte selection happens on the response.
        LANE_RE = '1;
      end
    end
  end

  // Pending response: a new accept wins over a same-cycle handshake so
  // back-to-back traffic keeps RSP_VALID high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_valid  <= 1'b0;
      p_we     <= 1'b0;
      p_err    <= 1'b0;
      p_funct3 <= 3'd0;
      p_off    <= 2'd0;
    end else if (accept) begin
      p_valid  <= 1'b1;
      p_we     <= REQ_WE;
      p_err    <= req_err;
      p_funct3 <= REQ_FUNCT3;
      p_off    <= req_off;
    end else if (p_valid && RSP_READY) begin
      p_valid  <= 1'b0;
    end
  end

  dmem_load_align u_align (
    .lane_dout (LANE_DOUT),
    .funct3    (p_funct3),
    .off       (p_off),
    .rdata     (aligned_rdata)
  );

  assign RSP_VALID = p_valid;
  assign RSP_ERR   = p_valid && p_err;
  assign RSP_RDATA = (p_valid && !p_we && !p_err) ? aligned_rdata : 32'd0;

endmodule
